cdc_toggle_hs_rx: RTL
=====================

Name: cdc_toggle_hs_rx

Overview:
Receive-side controller for a toggle-based request/acknowledge CDC link. It consumes the request toggle after the upstream 3-flop reset-capable synchronizer stage and captures the quasi-static data bus held by the transmitter. It presents the data to local logic through a valid/ready handshake and returns an acknowledge toggle to the transmit domain. It also keeps a transfer counter and a sticky protocol-error flag.

Parameters:
WIDTH, 8, data bus width (>=1)
CNT_W, 16, transfer counter width (>=1)
TIMEOUT_CYC, 1024, ready-stall limit in cycles; used only with the optional feature (>=2)

Ports:
clk  input  1  receive-domain clock
rstb  input  1  asynchronous active-low reset
req_tgl_sync  input  1  request toggle, already synchronized into clk domain by the upstream 3-flop synchronizer
data_in  input  WIDTH  transmit-domain data; transmitter holds it stable from req toggle until ack toggle returns
out_valid  output  1  captured data available
out_data  output  WIDTH  captured data
out_ready  input  1  local consumer accepts out_data
ack_tgl  output  1  acknowledge toggle to transmit domain (registered; tx side synchronizes it)
xfer_cnt  output  CNT_W  completed transfers, wrapping
err_ovf  output  1  sticky: request edge seen while busy
err_clr  input  1  synchronous clear of sticky error flags
err_timeout  output  1  sticky stall flag; only with CDC_HS_TIMEOUT_EN, otherwise tied 0

Behaviour:
- Interface decided: one clock clk; reset rstb is asynchronous and active-low.
- Reset (rstb=0, async): state IDLE, req_prev=0, out_valid=0, out_data=0, ack_tgl=0, xfer_cnt=0, err_ovf=0, err_timeout=0. Tx also resets req to 0, so no spurious edge occurs after reset.
- req_prev registers req_tgl_sync every cycle. edge = req_tgl_sync ^ req_prev.
- State machine: IDLE, VALID, ACK.
- IDLE:
  - If edge in cycle N: out_data <= data_in and state goes to VALID.
  - out_valid=1 from cycle N+1, giving 1-cycle latency from the synchronized edge.
- VALID:
  - out_valid=1 and out_data is held stable.
  - If out_ready=1: transfer completes and state goes to ACK next cycle.
  - out_valid=0 in the cycle after acceptance.
- ACK (one cycle):
  - ack_tgl inverts, xfer_cnt increments, state goes to IDLE.
  - Ack therefore toggles 2 cycles after the handshake cycle. The transfer is not acknowledged before the local consumer accepts it.
- xfer_cnt wraps from 2^CNT_W-1 to 0 silently.
- Edge in VALID or ACK is a tx protocol violation:
  - err_ovf <= 1 and the event is dropped (req_prev still tracks).
  - out_data is not overwritten; the current transfer proceeds normally.
- err_clr=1 clears err_ovf and err_timeout next cycle. A new error in the same cycle as err_clr wins (flag stays 1).
- out_ready while out_valid=0 is ignored.
- Asserting rstb mid-transfer: immediate return to reset values. The in-flight transfer is lost; system reset covers both domains.
- out_valid must not depend combinationally on out_ready.

Optional Feature:
- Macro: CDC_HS_TIMEOUT_EN.
- Defined:
  - A stall counter of width $clog2(TIMEOUT_CYC+1) counts consecutive VALID cycles with out_ready=0.
  - On reaching TIMEOUT_CYC: err_timeout <= 1 (sticky) and the counter saturates.
  - The counter clears on leaving VALID. The handshake is unaffected (keeps waiting).
- Undefined: no counter; err_timeout tied to 0.

Decomposition:
- Package cdc_hs_pkg: state enum typedef (IDLE, VALID, ACK); localparam encoding widths; timeout counter width function.
- One natural sub-module: cdc_toggle_edge_det (req_prev flop plus XOR, async active-low reset), reusable by the tx-side ack receiver.
- Synchronizer flops are not inside this block.

Test Plan:
- Reset then single transfer: data_in=8'hA5, toggle req_tgl_sync 0->1, out_ready=1 -> out_valid at +1 cycle with out_data=8'hA5; ack_tgl 0->1 two cycles after the handshake; xfer_cnt=1.
- Backpressure: out_ready=0 for 20 cycles after capture -> out_valid held 1 and out_data stable; ack_tgl unchanged until the cycle after ACK state.
- Overflow: second req toggle while in VALID -> err_ovf=1, out_data keeps first value; err_clr pulse -> err_ovf=0 next cycle.
- Wrap: CNT_W=2, 5 back-to-back transfers -> xfer_cnt sequence 1,2,3,0,1; ack_tgl toggles 5 times.
- Reset mid-transfer: rstb low while in VALID -> out_valid=0, ack_tgl=0, xfer_cnt=0 asynchronously; after release, the next toggle is received normally.
- With CDC_HS_TIMEOUT_EN, TIMEOUT_CYC=8: out_ready=0 for 8 VALID cycles -> err_timeout=1; then out_ready=1 -> transfer completes; err_timeout stays 1 until err_clr.

Source files
------------

// File: rtl/cdc_hs_pkg.sv
// Shared types for the toggle handshake CDC receiver: FSM state encoding and timeout counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdc_hs_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    function automatic int stall_cnt_w(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/cdc_toggle_edge_det.sv
// Detects a change on an already-synchronized toggle line (previous-value flop plus XOR).
// Latency: combinational pulse in the cycle the new level arrives.
// Backpressure: none; every toggle yields exactly one pulse.
module cdc_toggle_edge_det (
    input  logic clk,
    input  logic rstb,
    input  logic tgl,
    output logic tgl_edge
);

    logic tgl_prev;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) tgl_prev <= 1'b0;
        else       tgl_prev <= tgl;
    end

    assign tgl_edge = tgl ^ tgl_prev;

endmodule

// File: rtl/cdc_toggle_hs_rx.sv
// Toggle req/ack CDC receiver: captures held tx data, offers it valid/ready, returns ack toggle; CDC_HS_TIMEOUT_EN adds a stall flag.
// Latency: out_valid 1 cycle after the synchronized req edge; ack_tgl flips 2 cycles after the accepting cycle.
// Backpressure: out_valid/out_data hold until out_ready; the tx is not acknowledged before acceptance.
module cdc_toggle_hs_rx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             req_tgl_sync,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             ack_tgl,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err_ovf,
    input  logic             err_clr,
    output logic             err_timeout
);

    localparam int TO_W = stall_cnt_w(TIMEOUT_CYC);

    state_t state;
    state_t state_nxt;
    logic   req_edge;
    logic   capture;
    logic   ack_fire;
    logic   ovf_set;

    cdc_toggle_edge_det u_req_edge (
        .clk      (clk),
        .rstb     (rstb),
        .tgl      (req_tgl_sync),
        .tgl_edge (req_edge)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_edge)  state_nxt = VALID;
            VALID:   if (out_ready) state_nxt = ACK;
            ACK:                    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Decoded from state only, so out_valid never depends on out_ready.
    always_comb begin
        out_valid = (state == VALID);
        capture   = (state == IDLE) && req_edge;
        ack_fire  = (state == ACK);
        ovf_set   = req_edge && (state != IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_data <= '0;
            ack_tgl  <= 1'b0;
            xfer_cnt <= '0;
            err_ovf  <= 1'b0;
        end else begin
            if (capture)  out_data <= data_in;
            if (ack_fire) begin
                ack_tgl  <= ~ack_tgl;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            // A fresh violation outranks a clear in the same cycle.
            if (ovf_set)      err_ovf <= 1'b1;
            else if (err_clr) err_ovf <= 1'b0;
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    logic [TO_W-1:0] stall_cnt;
    logic            stalling;
    logic            stall_hit;

    assign stalling  = (state == VALID) && !out_ready;
    assign stall_hit = stalling && (stall_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (!stalling)                             stall_cnt <= '0;
            else if (stall_cnt != TO_W'(TIMEOUT_CYC))  stall_cnt <= stall_cnt + TO_W'(1);
            if (stall_hit)    err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TO_W > 0);
    assign err_timeout        = 1'b0;
`endif

endmodule
